conv2d_stream_core: RTL and testbench

Parametrised streaming KxK 2-D convolution core, the successor to the fixed 5x5 Gaussian core in the filter pipeline. It takes one KSIZE-pixel window column per accepted beat from the line-buffer window generator and runs a sequential systolic PE chain. The block adds run-time-loadable signed coefficients with a double-buffered bank, a programmable rounding shift, output saturation, valid/ready backpressure and line-start warm-up gating. The result stream feeds the downstream edge/threshold stages.

---
 rtl/conv_pkg.sv | 46 ++++
 rtl/conv_pe.sv | 40 ++++
 rtl/conv2d_stream_core.sv | 155 +++++++++++++++
 tb/tb_conv2d_stream_core.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// conv_pkg : shared types and helpers for conv2d_stream_core    (rev 1.0)
// ============================================================================
package conv_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWAP  = 2'd2
    } state_t;

    // Config address of the shift register; coefficients occupy 0..K*K-1.
    function automatic int shift_slot(input int ksize);
        return ksize * ksize;
    endfunction

    // Identity kernel: centre tap (r=c=(K-1)/2, flat index (K*K)/2) is 1.
    function automatic int identity_tap(input int ksize, input int idx);
        return (idx == (ksize * ksize) / 2) ? 1 : 0;
    endfunction

    // Round-half-up, arithmetic shift, then clamp into the unsigned pixel range.
    function automatic int sat_round(input logic signed [63:0] sum,
                                     input int                 shift,
                                     input int                 pix_w);
        logic signed [63:0] biased;
        logic signed [63:0] scaled;
        logic signed [63:0] max_val;
        biased = sum;
        if (shift > 0) begin
            biased = sum + (64'sd1 <<< (shift - 1));
        end
        scaled  = biased >>> shift;
        max_val = (64'sd1 <<< pix_w) - 64'sd1;
        if (scaled < 64'sd0) begin
            return 0;
        end
        if (scaled > max_val) begin
            return int'(max_val);
        end
        return int'(scaled);
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_pe.sv
`default_nettype none
// ============================================================================
// conv_pe : registered multiply-accumulate tap with advance enable (rev 1.0)
// ============================================================================
module conv_pe #(
    parameter int PIXEL_WIDTH = 8,
    parameter int COEFF_WIDTH = 8,
    parameter int ACCUM_WIDTH = 24
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          adv,
    input  logic [PIXEL_WIDTH-1:0]        pix,
    input  logic signed [COEFF_WIDTH-1:0] coeff,
    input  logic signed [ACCUM_WIDTH-1:0] acc_in,
    output logic signed [ACCUM_WIDTH-1:0] acc_out
);

    localparam int PROD_WIDTH = PIXEL_WIDTH + COEFF_WIDTH + 1;

    logic signed [ACCUM_WIDTH-1:0] acc_q;
    logic signed [PIXEL_WIDTH:0]   pix_s;
    logic signed [PROD_WIDTH-1:0]  prod;

    // The register holds the upstream partial sum from the previous beat, so
    // the current column's product is added combinationally at this tap.
    assign pix_s   = {1'b0, pix};
    assign prod    = PROD_WIDTH'(pix_s) * PROD_WIDTH'(coeff);
    assign acc_out = acc_q + ACCUM_WIDTH'(prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (adv) begin
            acc_q <= acc_in;
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv2d_stream_core.sv
`default_nettype none
// ============================================================================
// conv2d_stream_core : streaming KxK convolution with double-buffered taps (rev 1.0)
// ============================================================================
module conv2d_stream_core
    import conv_pkg::*;
#(
    parameter int KSIZE       = 5,
    parameter int PIXEL_WIDTH = 8,
    parameter int COEFF_WIDTH = 8,
    parameter int ACCUM_WIDTH = 24,
    parameter int SHIFT_WIDTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic                                 in_sol,
    input  logic [KSIZE*PIXEL_WIDTH-1:0]         in_col,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [PIXEL_WIDTH-1:0]               out_pixel,
    input  logic                                 cfg_wr_en,
    input  logic [$clog2(KSIZE*KSIZE+1)-1:0]     cfg_addr,
    input  logic [COEFF_WIDTH-1:0]               cfg_wdata,
    input  logic                                 cfg_commit,
    output logic                                 cfg_busy
);

    localparam int NTAPS      = KSIZE * KSIZE;
    localparam int SHIFT_ADDR = shift_slot(KSIZE);
    localparam int WCNT_WIDTH = $clog2(KSIZE + 1);

    state_t                        state;
    state_t                        state_nxt;
    logic signed [COEFF_WIDTH-1:0] shadow_coeff [NTAPS];
    logic signed [COEFF_WIDTH-1:0] active_coeff [NTAPS];
    logic [SHIFT_WIDTH-1:0]        shadow_shift;
    logic [SHIFT_WIDTH-1:0]        active_shift;
    logic [WCNT_WIDTH-1:0]         wcnt;
    logic [WCNT_WIDTH-1:0]         wcnt_nxt;
    logic                          accept;
    logic                          produce;
    logic signed [ACCUM_WIDTH-1:0] chain [KSIZE][KSIZE];
    logic signed [ACCUM_WIDTH-1:0] final_sum;
    logic [PIXEL_WIDTH-1:0]        result;

    assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign cfg_busy = (state != ST_RUN);

    // PE array: one chain per kernel row, oldest column enters at tap 0.
    for (genvar r = 0; r < KSIZE; r++) begin : g_row
        for (genvar c = 0; c < KSIZE; c++) begin : g_col
            logic signed [ACCUM_WIDTH-1:0] acc_in;
            if (c == 0) begin : g_first
                assign acc_in = '0;
            end else begin : g_next
                assign acc_in = chain[r][c-1];
            end
            conv_pe #(
                .PIXEL_WIDTH (PIXEL_WIDTH),
                .COEFF_WIDTH (COEFF_WIDTH),
                .ACCUM_WIDTH (ACCUM_WIDTH)
            ) u_pe (
                .clk     (clk),
                .rst_n   (rst_n),
                .adv     (accept),
                .pix     (in_col[r*PIXEL_WIDTH +: PIXEL_WIDTH]),
                .coeff   (active_coeff[r*KSIZE+c]),
                .acc_in  (acc_in),
                .acc_out (chain[r][c])
            );
        end
    end

    always_comb begin
        final_sum = '0;
        for (int r = 0; r < KSIZE; r++) begin
            final_sum = final_sum + chain[r][KSIZE-1];
        end
        result = PIXEL_WIDTH'(sat_round({{(64-ACCUM_WIDTH){final_sum[ACCUM_WIDTH-1]}}, final_sum},
                                        int'(active_shift), PIXEL_WIDTH));
    end

    always_comb begin
        wcnt_nxt = wcnt;
        if (accept) begin
            if (in_sol) begin
                wcnt_nxt = WCNT_WIDTH'(1);
            end else if (wcnt != WCNT_WIDTH'(KSIZE)) begin
                wcnt_nxt = wcnt + 1'b1;
            end
        end
        produce = accept && (wcnt_nxt == WCNT_WIDTH'(KSIZE));
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RUN:   if (cfg_commit) state_nxt = ST_DRAIN;
            ST_DRAIN: if (!out_valid || out_ready) state_nxt = ST_SWAP;
            ST_SWAP:  state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= (state == ST_SWAP) ? '0 : wcnt_nxt;
        end
    end

    // Shadow bank takes writes outside SWAP; active bank changes only in SWAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++) begin
                shadow_coeff[i] <= COEFF_WIDTH'(identity_tap(KSIZE, i));
                active_coeff[i] <= COEFF_WIDTH'(identity_tap(KSIZE, i));
            end
            shadow_shift <= '0;
            active_shift <= '0;
        end else begin
            if (cfg_wr_en && (state != ST_SWAP)) begin
                if (int'(cfg_addr) < NTAPS) begin
                    shadow_coeff[cfg_addr] <= cfg_wdata;
                end else if (int'(cfg_addr) == SHIFT_ADDR) begin
                    shadow_shift <= cfg_wdata[SHIFT_WIDTH-1:0];
                end
            end
            if (state == ST_SWAP) begin
                active_coeff <= shadow_coeff;
                active_shift <= shadow_shift;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pixel <= '0;
        end else if (produce) begin
            out_valid <= 1'b1;
            out_pixel <= result;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv2d_stream_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_conv2d_stream_core : directed self-checking bench (rev 1.0)
// ============================================================================
module tb_conv2d_stream_core;

    localparam int K  = 5;
    localparam int PW = 8;
    localparam int CW = 8;
    localparam int AW = 24;
    localparam int SW = 4;
    localparam int AD = $clog2(K*K+1);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic            in_sol;
    logic [K*PW-1:0] in_col;
    logic            out_valid;
    logic            out_ready;
    logic [PW-1:0]   out_pixel;
    logic            cfg_wr_en;
    logic [AD-1:0]   cfg_addr;
    logic [CW-1:0]   cfg_wdata;
    logic            cfg_commit;
    logic            cfg_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    conv2d_stream_core #(
        .KSIZE(K), .PIXEL_WIDTH(PW), .COEFF_WIDTH(CW), .ACCUM_WIDTH(AW), .SHIFT_WIDTH(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sol(in_sol), .in_col(in_col),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_commit(cfg_commit), .cfg_busy(cfg_busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [K*PW-1:0] col_row2(input logic [PW-1:0] centre, input logic [PW-1:0] other);
        logic [K*PW-1:0] c;
        for (int r = 0; r < K; r++) c[r*PW +: PW] = (r == 2) ? centre : other;
        return c;
    endfunction

    task automatic cfg_write(input int addr, input int data);
        cfg_wr_en = 1'b1; cfg_addr = AD'(addr); cfg_wdata = CW'(data);
        tick;
        cfg_wr_en = 1'b0;
    endtask

    task automatic commit_and_wait;
        cfg_commit = 1'b1;
        tick;
        cfg_commit = 1'b0;
        for (int i = 0; i < 8 && cfg_busy; i++) tick;
        total++;
        if (cfg_busy !== 1'b0) begin bad++; $display("FAIL commit_timeout busy=%b want=0", cfg_busy); end
    endtask

    task automatic load_centre(input int coef, input int shift);
        for (int i = 0; i < K*K; i++) cfg_write(i, (i == 12) ? coef : 0);
        cfg_write(K*K, shift);
        commit_and_wait();
    endtask

    // Streams n beats of a uniform column without in_sol, then checks the last result.
    task automatic test_saturation;
        int coefs [4] = '{127, -1, 3, 2};
        int shs   [4] = '{0, 0, 1, 0};
        int pixs  [4] = '{255, 255, 5, 128};
        int exps  [4] = '{255, 0, 8, 255};
        for (int k = 0; k < 4; k++) begin
            load_centre(coefs[k], shs[k]);
            in_col = col_row2(PW'(pixs[k]), PW'(pixs[k]));
            for (int t = 0; t < K; t++) begin in_valid = 1'b1; tick; end
            in_valid = 1'b0;
            total++;
            if (out_valid !== 1'b1 || out_pixel !== PW'(exps[k])) begin
                bad++; $display("FAIL sat_case%0d valid=%b pixel=%0d want valid=1 pixel=%0d", k, out_valid, out_pixel, exps[k]);
            end
            tick;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick; tick;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_pixel !== '0)   begin bad++; $display("FAIL reset_out_pixel got=%0d want=0", out_pixel); end
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (cfg_busy !== 1'b0)  begin bad++; $display("FAIL reset_cfg_busy got=%b want=0", cfg_busy); end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_identity;
        logic exp_v;
        for (int t = 0; t < 12; t++) begin
            in_valid = 1'b1; in_sol = (t == 0); in_col = col_row2(PW'(t), 8'd77);
            tick;
            exp_v = (t >= 4);
            total++;
            if (out_valid !== exp_v) begin bad++; $display("FAIL ident_valid beat=%0d got=%b want=%b", t, out_valid, exp_v); end
            if (exp_v) begin
                total++;
                if (out_pixel !== PW'(t-2)) begin bad++; $display("FAIL ident_pixel beat=%0d got=%0d want=%0d", t, out_pixel, t-2); end
            end
        end
        in_valid = 1'b0; in_sol = 1'b0;
        tick;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ident_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_gaussian;
        int b [5] = '{1, 4, 6, 4, 1};
        logic exp_v;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++) cfg_write(r*K+c, b[r]*b[c]);
        cfg_write(K*K, 8);
        cfg_commit = 1'b1;
        tick;
        cfg_commit = 1'b0;
        total++; if (cfg_busy !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL gauss_drain busy=%b rdy=%b want 1,0", cfg_busy, in_ready); end
        tick;
        total++; if (cfg_busy !== 1'b1) begin bad++; $display("FAIL gauss_swap busy=%b want=1", cfg_busy); end
        tick;
        total++; if (cfg_busy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL gauss_run busy=%b rdy=%b want 0,1", cfg_busy, in_ready); end
        in_col = col_row2(8'd200, 8'd200);
        for (int t = 1; t <= 7; t++) begin
            in_valid = 1'b1;
            tick;
            exp_v = (t >= 5);
            total++;
            if (out_valid !== exp_v || (exp_v && out_pixel !== 8'd200)) begin
                bad++; $display("FAIL gauss_beat%0d valid=%b pixel=%0d want valid=%b pixel=200", t, out_valid, out_pixel, exp_v);
            end
        end
        in_valid = 1'b0;
        tick;
    endtask

    task automatic test_backpressure;
        load_centre(1, 0);
        for (int t = 0; t < 6; t++) begin
            in_valid = 1'b1; in_sol = (t == 0); in_col = col_row2(PW'(10+t), 8'd3);
            tick;
        end
        in_sol = 1'b0;
        total++; if (out_valid !== 1'b1 || out_pixel !== 8'd13) begin bad++; $display("FAIL bp_pre valid=%b pixel=%0d want 1,13", out_valid, out_pixel); end
        in_col = col_row2(8'd16, 8'd3); out_ready = 1'b0;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_drop got=%b want=0", in_ready); end
        for (int s = 0; s < 3; s++) begin
            tick;
            total++;
            if (out_valid !== 1'b1 || out_pixel !== 8'd13 || in_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold%0d valid=%b pixel=%0d rdy=%b want 1,13,0", s, out_valid, out_pixel, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b want=1", in_ready); end
        tick;
        total++; if (out_valid !== 1'b1 || out_pixel !== 8'd14) begin bad++; $display("FAIL bp_resume0 valid=%b pixel=%0d want 1,14", out_valid, out_pixel); end
        in_col = col_row2(8'd17, 8'd3);
        tick;
        total++; if (out_valid !== 1'b1 || out_pixel !== 8'd15) begin bad++; $display("FAIL bp_resume1 valid=%b pixel=%0d want 1,15", out_valid, out_pixel); end
        in_valid = 1'b0;
        tick;
    endtask

    task automatic test_commit_stall;
        for (int t = 0; t < 5; t++) begin
            in_valid = 1'b1; in_sol = (t == 0); in_col = col_row2(PW'(50+t), 8'd9);
            tick;
        end
        in_valid = 1'b0; in_sol = 1'b0; out_ready = 1'b0; cfg_commit = 1'b1;
        tick;
        cfg_commit = 1'b0;
        total++; if (cfg_busy !== 1'b1 || out_valid !== 1'b1 || out_pixel !== 8'd52) begin
            bad++; $display("FAIL cs_enter busy=%b valid=%b pixel=%0d want 1,1,52", cfg_busy, out_valid, out_pixel); end
        cfg_write(12, 2);
        cfg_commit = 1'b1;
        tick;
        cfg_commit = 1'b0;
        total++; if (cfg_busy !== 1'b1 || in_ready !== 1'b0 || out_pixel !== 8'd52) begin
            bad++; $display("FAIL cs_hold busy=%b rdy=%b pixel=%0d want 1,0,52", cfg_busy, in_ready, out_pixel); end
        out_ready = 1'b1;
        tick;
        total++; if (cfg_busy !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL cs_swap busy=%b valid=%b want 1,0", cfg_busy, out_valid); end
        cfg_commit = 1'b1; cfg_wr_en = 1'b1; cfg_addr = AD'(12); cfg_wdata = 8'd3;
        tick;
        cfg_commit = 1'b0; cfg_wr_en = 1'b0;
        total++; if (cfg_busy !== 1'b0) begin bad++; $display("FAIL cs_run busy=%b want=0", cfg_busy); end
        tick;
        total++; if (cfg_busy !== 1'b0) begin bad++; $display("FAIL cs_second_commit busy=%b want=0", cfg_busy); end
        in_col = col_row2(8'd30, 8'd30);
        for (int t = 0; t < K; t++) begin in_valid = 1'b1; tick; end
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_pixel !== 8'd60) begin
            bad++; $display("FAIL cs_newbank valid=%b pixel=%0d want 1,60", out_valid, out_pixel); end
        tick;
    endtask

    task automatic test_reset_mid_line;
        load_centre(4, 0);
        for (int t = 0; t < 5; t++) begin
            in_valid = 1'b1; in_sol = (t == 0); in_col = col_row2(8'd20, 8'd20);
            tick;
        end
        in_sol = 1'b0;
        total++; if (out_valid !== 1'b1 || out_pixel !== 8'd80) begin
            bad++; $display("FAIL rm_pre valid=%b pixel=%0d want 1,80", out_valid, out_pixel); end
        in_valid = 1'b0; rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || out_pixel !== '0 || in_ready !== 1'b1 || cfg_busy !== 1'b0) begin
            bad++; $display("FAIL rm_reset valid=%b pixel=%0d rdy=%b busy=%b want 0,0,1,0", out_valid, out_pixel, in_ready, cfg_busy); end
        tick;
        rst_n = 1'b1;
        tick;
        for (int t = 0; t < 5; t++) begin
            in_valid = 1'b1; in_sol = (t == 0); in_col = col_row2(8'd7, 8'd90);
            tick;
            if (t == 3) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_warmup valid=%b want=0", out_valid); end
            end
        end
        in_valid = 1'b0; in_sol = 1'b0;
        total++; if (out_valid !== 1'b1 || out_pixel !== 8'd7) begin
            bad++; $display("FAIL rm_identity valid=%b pixel=%0d want 1,7", out_valid, out_pixel); end
        tick;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sol = 1'b0; in_col = '0; out_ready = 1'b1;
        cfg_wr_en = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0;
        test_reset();
        test_identity();
        test_gaussian();
        test_saturation();
        test_backpressure();
        test_commit_stall();
        test_reset_mid_line();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
